// File: rtl/seq_det_pkg.sv
// Shared defaults and legal bounds for the serial pattern detector.
package seq_det_pkg;

  localparam int SEQ_PAT_LEN_DEF = 3;
  localparam int SEQ_CNT_W_DEF   = 8;
  localparam int SEQ_PAT_LEN_MIN = 2;
  localparam int SEQ_PAT_LEN_MAX = 16;

  function automatic bit pat_len_legal(input int n);
    return (n >= SEQ_PAT_LEN_MIN) && (n <= SEQ_PAT_LEN_MAX);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for the detector match count.
// Only compiled when DET_COUNT_EN is defined, so the default build carries no counter logic.
`ifdef DET_COUNT_EN
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule
`endif

// File: rtl/seq_detector.sv
// Serial MSB-first pattern detector with a combinational (Mealy) match flag.
// Defining DET_COUNT_EN adds a saturating match counter; otherwise match_count reads 0.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_LEN = SEQ_PAT_LEN_DEF,
  parameter int CNT_W   = SEQ_CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pat,
  input  logic               overlap,
  input  logic               x_valid,
  input  logic               x,
  output logic               y,
  output logic [CNT_W-1:0]   match_count
);

  localparam int                FILL_W   = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  if (!pat_len_legal(PAT_LEN)) begin : g_bad_pat_len
    $error("seq_detector: PAT_LEN out of range");
  end

  logic [PAT_LEN-1:0] r_pat_reg;
  logic [PAT_LEN-2:0] r_hist;
  logic [FILL_W-1:0]  r_fill;

  logic [PAT_LEN-1:0] w_window;
  logic               w_full;
  logic               w_hit;

  // Window is the last PAT_LEN-1 valid bits plus the bit arriving this cycle.
  always_comb begin
    w_window = {r_hist, x};
    w_full   = (r_fill == FILL_MAX);
    w_hit    = (w_window == r_pat_reg);
    y        = x_valid & ~load & ~reset & w_full & w_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat_reg <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
    end else if (load) begin
      r_pat_reg <= pat;
      r_hist    <= '0;
      r_fill    <= '0;
    end else if (x_valid) begin
      r_hist <= w_window[PAT_LEN-2:0];
      // Non-overlapping mode demands a full set of fresh bits after a match.
      if (y && !overlap) begin
        r_fill <= '0;
      end else if (!w_full) begin
        r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

`ifdef DET_COUNT_EN
  sat_counter #(
    .W (CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (y),
    .q     (match_count)
  );
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector: directed scenarios plus random traffic
// checked against a queue-based reference of the detection rules.
module tb_seq_detector;

`ifdef DET_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  localparam int P3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // DUT with default-sized pattern and an 8-bit counter
  logic       rst3 = 1'b1, load3 = 1'b0, ov3 = 1'b0, xv3 = 1'b0, x3 = 1'b0;
  logic [2:0] pat3 = '0;
  logic       y3;
  logic [7:0] cnt3;

  seq_detector #(.PAT_LEN(3), .CNT_W(8)) u_dut3 (
    .clk         (clk),
    .reset       (rst3),
    .load        (load3),
    .pat         (pat3),
    .overlap     (ov3),
    .x_valid     (xv3),
    .x           (x3),
    .y           (y3),
    .match_count (cnt3)
  );

  // DUT with a 2-bit pattern and a 2-bit counter for saturation
  logic       rst2 = 1'b1, load2 = 1'b0, ov2 = 1'b0, xv2 = 1'b0, x2 = 1'b0;
  logic [1:0] pat2 = '0;
  logic       y2;
  logic [1:0] cnt2;

  seq_detector #(.PAT_LEN(2), .CNT_W(2)) u_dut2 (
    .clk         (clk),
    .reset       (rst2),
    .load        (load2),
    .pat         (pat2),
    .overlap     (ov2),
    .x_valid     (xv2),
    .x           (x2),
    .y           (y2),
    .match_count (cnt2)
  );

  // Reference: valid bits seen since the last clear, current pattern, match count
  bit         m_q[$];
  logic [2:0] m_pat = '0;
  int         m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_y(input logic ld, input logic xv, input logic xb);
    int n;
    bit ok;
    if (!xv || ld) return 1'b0;
    n = m_q.size();
    if (n < P3 - 1) return 1'b0;
    ok = (xb == m_pat[0]);
    for (int i = 1; i < P3; i++)
      if (m_q[n - i] != m_pat[i]) ok = 1'b0;
    return ok;
  endfunction

  task automatic step3(input logic ld, input logic [2:0] p, input logic ov,
                       input logic xv, input logic xb, input int dir_y, input string tag);
    bit ey;
    @(negedge clk);
    load3 = ld; pat3 = p; ov3 = ov; xv3 = xv; x3 = xb;
    #1;
    ey = model_y(ld, xv, xb);
    check({tag, "_y"}, {31'd0, y3}, (dir_y >= 0) ? dir_y : {31'd0, ey});
    @(posedge clk);
    #1;
    if (ld) begin
      m_pat = p;
      m_q.delete();
    end else if (xv) begin
      if (ey && !ov) m_q.delete();
      else begin
        m_q.push_back(xb);
        if (m_q.size() > P3) void'(m_q.pop_front());
      end
    end
    if (ey && CNT_ON && m_cnt < 255) m_cnt++;
    check({tag, "_cnt"}, {24'd0, cnt3}, m_cnt);
  endtask

  task automatic reset3(input string tag);
    @(negedge clk);
    xv3 = 1'b1; x3 = 1'b1; load3 = 1'b0;
    rst3 = 1'b1;
    #1;
    check({tag, "_rst_y"}, {31'd0, y3}, 0);
    check({tag, "_rst_cnt"}, {24'd0, cnt3}, 0);
    @(posedge clk);
    #1;
    m_q.delete();
    m_pat = '0;
    m_cnt = 0;
    @(negedge clk);
    rst3 = 1'b0; xv3 = 1'b0;
  endtask

  task automatic step2(input logic xb, input int dir_y, input int dir_cnt, input string tag);
    @(negedge clk);
    load2 = 1'b0; xv2 = 1'b1; x2 = xb;
    #1;
    check({tag, "_y"}, {31'd0, y2}, dir_y);
    @(posedge clk);
    #1;
    if (dir_cnt >= 0) check({tag, "_cnt"}, {30'd0, cnt2}, CNT_ON ? dir_cnt : 0);
  endtask

  initial begin
    logic       ld, ov, xv, xb;
    logic [2:0] p;

    // Reset state
    #2;
    check("por_y3", {31'd0, y3}, 0);
    check("por_cnt3", {24'd0, cnt3}, 0);
    check("por_cnt2", {30'd0, cnt2}, 0);
    @(negedge clk);
    rst3 = 1'b0; rst2 = 1'b0;

    // All-zero stream matches the reset pattern after three bits
    step3(0, 3'b000, 1, 1, 0, 0, "zero_b1");
    step3(0, 3'b000, 1, 1, 0, 0, "zero_b2");
    step3(0, 3'b000, 1, 1, 0, 1, "zero_b3");

    // Overlapping 111 on 0,1,1,1,1,0
    reset3("r030");
    step3(1, 3'b111, 1, 1, 0, 0, "r030_ld");
    step3(0, 3'b000, 1, 1, 0, 0, "r030_b1");
    step3(0, 3'b000, 1, 1, 1, 0, "r030_b2");
    step3(0, 3'b000, 1, 1, 1, 0, "r030_b3");
    step3(0, 3'b000, 1, 1, 1, 1, "r030_b4");
    step3(0, 3'b000, 1, 1, 1, 1, "r030_b5");
    step3(0, 3'b000, 1, 1, 0, 0, "r030_b6");
    check("r030_total", {24'd0, cnt3}, CNT_ON ? 2 : 0);

    // Same stream, non-overlapping
    reset3("r031");
    step3(1, 3'b111, 0, 1, 0, 0, "r031_ld");
    step3(0, 3'b000, 0, 1, 0, 0, "r031_b1");
    step3(0, 3'b000, 0, 1, 1, 0, "r031_b2");
    step3(0, 3'b000, 0, 1, 1, 0, "r031_b3");
    step3(0, 3'b000, 0, 1, 1, 1, "r031_b4");
    step3(0, 3'b000, 0, 1, 1, 0, "r031_b5");
    step3(0, 3'b000, 0, 1, 0, 0, "r031_b6");
    check("r031_total", {24'd0, cnt3}, CNT_ON ? 1 : 0);

    // 101 with invalid cycles interleaved (x toggles while invalid)
    reset3("r032");
    step3(1, 3'b101, 1, 1, 0, 0, "r032_ld");
    step3(0, 3'b000, 1, 1, 1, 0, "r032_v1");
    step3(0, 3'b000, 1, 0, 1, 0, "r032_i1");
    step3(0, 3'b000, 1, 1, 0, 0, "r032_v2");
    step3(0, 3'b000, 1, 0, 1, 0, "r032_i2");
    step3(0, 3'b000, 1, 1, 1, 1, "r032_v3");
    step3(0, 3'b000, 1, 0, 1, 0, "r032_i3");
    step3(0, 3'b000, 1, 1, 0, 0, "r032_v4");
    step3(0, 3'b000, 1, 0, 0, 0, "r032_i4");
    step3(0, 3'b000, 1, 1, 1, 1, "r032_v5");
    check("r032_total", {24'd0, cnt3}, CNT_ON ? 2 : 0);

    // Reset mid-sequence discards history
    reset3("r033a");
    step3(1, 3'b111, 1, 1, 1, 0, "r033_ld");
    step3(0, 3'b000, 1, 1, 1, 0, "r033_b1");
    step3(0, 3'b000, 1, 1, 1, 0, "r033_b2");
    reset3("r033b");
    step3(1, 3'b111, 1, 1, 1, 0, "r033_reld");
    step3(0, 3'b000, 1, 1, 1, 0, "r033_b3");
    step3(0, 3'b000, 1, 1, 1, 0, "r033_b4");
    step3(0, 3'b000, 1, 1, 1, 1, "r033_b5");

    // Load clears history and wins over x_valid
    reset3("r035");
    step3(0, 3'b000, 1, 1, 1, 0, "r035_b1");
    step3(0, 3'b000, 1, 1, 1, 0, "r035_b2");
    step3(1, 3'b110, 1, 1, 0, 0, "r035_ld");
    step3(0, 3'b000, 1, 1, 0, 0, "r035_b3");
    step3(0, 3'b000, 1, 1, 1, 0, "r035_b4");
    step3(0, 3'b000, 1, 1, 1, 0, "r035_b5");
    step3(0, 3'b000, 1, 1, 0, 1, "r035_b6");

    // Counter saturation on the 2-bit instance
    @(negedge clk);
    load2 = 1'b1; pat2 = 2'b11; ov2 = 1'b1; xv2 = 1'b1; x2 = 1'b1;
    #1;
    check("r034_ld_y", {31'd0, y2}, 0);
    step2(1, 0, 0, "r034_b1");
    step2(1, 1, 1, "r034_b2");
    step2(1, 1, 2, "r034_b3");
    step2(1, 1, 3, "r034_b4");
    step2(1, 1, 3, "r034_b5");
    step2(1, 1, 3, "r034_b6");
    @(negedge clk);
    xv2 = 1'b0;

    // Random traffic against the reference
    reset3("rnd");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) reset3($sformatf("rnd_rst%0d", i));
      ld = ($urandom_range(0, 19) == 0);
      p  = 3'($urandom);
      ov = 1'($urandom);
      xv = ($urandom_range(0, 3) != 0);
      xb = 1'($urandom);
      step3(ld, p, ov, xv, xb, -1, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter PAT_LEN, default 3: pattern length in bits, legal range 2..16.
REQ-002 Parameter CNT_W, default 8: match-counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load  input  1  pattern load strobe.
REQ-006 pat  input  PAT_LEN  pattern value, sampled when load=1.
REQ-007 overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
REQ-008 x_valid  input  1  qualifies x for the current cycle.
REQ-009 x  input  1  serial data bit.
REQ-010 y  output  1  Mealy match flag, combinational, same cycle as the completing bit.
REQ-011 match_count  output  CNT_W  saturating count of asserted y cycles (DET_COUNT_EN only).

Function
REQ-012 Bits compare MSB-first: the oldest of the last PAT_LEN valid bits matches pat_reg[PAT_LEN-1], and the current x matches pat_reg[0].
REQ-013 State: pat_reg (PAT_LEN bits), hist (PAT_LEN-1 bits; shifts left, x enters the LSB), fill counter (0..PAT_LEN-1, saturating).
REQ-014 y = x_valid & ~load & (fill == PAT_LEN-1) & ({hist, x} == pat_reg); y has no registered delay.
REQ-015 On a clock edge with x_valid=1 and load=0, hist shifts in x and fill increments, saturating at PAT_LEN-1.
REQ-016 Non-overlap mode: a cycle with y=1 and overlap=0 clears fill to 0 instead of incrementing, so the next match requires PAT_LEN fresh bits.
REQ-017 Overlap mode: a cycle with y=1 and overlap=1 follows REQ-015 unchanged.
REQ-018 With x_valid=0, hist, fill and match_count hold, and y=0.
REQ-019 With load=1, pat_reg takes pat, hist and fill clear to 0, and y=0; x is ignored in that cycle. load has priority over x_valid.
REQ-020 match_count increments by 1 on each edge where y=1, and holds at 2^CNT_W-1 without wrapping.
REQ-021 load does not clear match_count; only reset clears it.

Reset
REQ-022 Reset asserted: pat_reg=0, hist=0, fill=0, match_count=0, and y=0 immediately without waiting for a clock edge.
REQ-023 Reset mid-sequence discards partial history; detection restarts from fill=0 after reset deasserts.
REQ-024 pat_reg reset value 0 is a valid pattern: an all-zero stream matches after PAT_LEN valid bits.

Configuration
REQ-025 Macro DET_COUNT_EN defined: the match_count register, saturation logic and output port are present.
REQ-026 DET_COUNT_EN undefined: no counter logic; match_count is tied to 0. The port list stays unchanged and REQ-001 to REQ-024 are otherwise unaffected.

Structure
REQ-027 Shared package seq_det_pkg holds the PAT_LEN and CNT_W defaults and the legal PAT_LEN bounds (2, 16).
REQ-028 Sub-module sat_counter (parameter W; inputs clk, reset, inc; output q) implements REQ-020 and is instantiated only under DET_COUNT_EN.
REQ-029 The state update is a single registered block with asynchronous reset; y and the compare are a separate combinational block.

Verification
REQ-030 PAT_LEN=3, load pat=3'b111, overlap=1, x=0,1,1,1,1,0 all valid -> y=1 on the 4th and 5th bits; match_count=2.
REQ-031 Same stream with overlap=0 -> y=1 on the 4th bit only; match_count=1.
REQ-032 pat=3'b101, overlap=1, x=1,0,1,0,1 with x_valid=0 cycles interleaved between bits -> y=1 on the 3rd and 5th valid bits only; y=0 on every invalid cycle.
REQ-033 pat=3'b111, drive x=1,1, assert reset for 1 cycle, then x=1 -> y=0. Two further 1s -> y=1.
REQ-034 CNT_W=2, pat=2'b11, overlap=1, six consecutive 1s -> match_count reads 1, 2, 3, 3, 3.
REQ-035 load pat=3'b110 after x=1,1; next x=0 -> y=0 because history was cleared. Then x=1,1,0 -> y=1 on the 0.
